// File: rtl/rv_boot_pkg.sv
// rtl/rv_boot_pkg.sv - shared types and constants for the imem boot loader
package rv_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM
  } boot_state_t;

  localparam logic [7:0] BOOT_SYNC = 8'hA5;

endpackage

// File: rtl/boot_rx_timer.sv
// rtl/boot_rx_timer.sv - inter-byte idle counter with clear, enable and expiry
module boot_rx_timer #(
  parameter int TIMEOUT = 1 << 20
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // The owner gives an accepted byte priority over this strobe.
  assign expire = enable && (count == LAST);

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot frame parser packing UART bytes into imem words
module imem_boot_loader
  import rv_boot_pkg::*;
#(
  parameter int         ADDR_W  = 11,
  parameter int         TIMEOUT = 1 << 20,
  parameter logic [7:0] SYNC    = BOOT_SYNC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              boot_done,
  output logic              err
);

  localparam logic [16:0] DEPTH = 17'(1 << ADDR_W);

  boot_state_t       state;
  logic [7:0]        len_lo;
  logic [7:0]        sum;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] n_last;
  logic [1:0]        lane;
  logic [23:0]       word;
  logic              accept;
  logic              expire;
  logic [15:0]       len_word;

  assign accept   = rx_valid && rx_ready;
  assign len_word = {rx_data, len_lo};

  boot_rx_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .clear (rst || accept || state == IDLE),
    .enable(state != IDLE),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      boot_done <= 1'b0;
      err       <= 1'b0;
      len_lo    <= '0;
      sum       <= '0;
      widx      <= '0;
      n_last    <= '0;
      lane      <= '0;
      word      <= '0;
    end else begin
      rx_ready <= 1'b1;
      mem_we   <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC) begin
              state     <= LEN_LO;
              busy      <= 1'b1;
              boot_done <= 1'b0;
              err       <= 1'b0;
              sum       <= '0;
              widx      <= '0;
              lane      <= '0;
            end
          end
          LEN_LO: begin
            len_lo <= rx_data;
            state  <= LEN_HI;
          end
          LEN_HI: begin
            if ({1'b0, len_word} > DEPTH) begin
              err   <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else if (len_word == 16'd0) begin
              state <= CSUM;
            end else begin
              n_last <= ADDR_W'(len_word - 16'd1);
              state  <= DATA;
            end
          end
          DATA: begin
            sum  <= sum + rx_data;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= widx;
              mem_wdata <= {rx_data, word};
              // A full-depth image wraps widx to 0 only on the final write.
              widx      <= widx + 1'b1;
              if (widx == n_last) begin
                state <= CSUM;
              end
            end else begin
              word[8*lane +: 8] <= rx_data;
            end
          end
          CSUM: begin
            if (rx_data == sum) begin
              boot_done <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (expire) begin
        err   <= 1'b1;
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;

  localparam int ADDR_W  = 11;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              boot_done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W+31:0] exp_q[$];

  imem_boot_loader #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .SYNC   (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .boot_done(boot_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e[ADDR_W+31:32]));
        check("write_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send_good_body(input logic [7:0] csum);
    logic [7:0] body [12];
    body = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, csum};
    for (int i = 0; i < 12; i++) send(body[i]);
  endtask

  task automatic check_status(input string tag, input logic bd, input logic er, input logic bs);
    check({tag, "_boot_done"}, 32'(boot_done), 32'(bd));
    check({tag, "_err"}, 32'(err), 32'(er));
    check({tag, "_busy"}, 32'(busy), 32'(bs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rx_ready_up", 32'(rx_ready), 32'd1);

    // 1: two-word frame with good checksum
    expect_write(11'd0, 32'h00000013);
    expect_write(11'd1, 32'h00100093);
    send_good_body(8'hB6);
    check_status("t1", 1'b1, 1'b0, 1'b0);

    // 2: same frame, bad checksum; words still written
    expect_write(11'd0, 32'h00000013);
    expect_write(11'd1, 32'h00100093);
    send_good_body(8'h00);
    check_status("t2", 1'b0, 1'b1, 1'b0);

    // 3: oversize length aborts at LEN_HI
    send(8'hA5); send(8'h01); send(8'h08);
    check_status("t3", 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_status("t3_hold", 1'b0, 1'b1, 1'b0);

    // 4: timeout after a partial word, then recovery
    send(8'hA5); send(8'h01); send(8'h00); send(8'h13); send(8'h00);
    repeat (15) @(negedge clk);
    check_status("t4_before", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_status("t4_expired", 1'b0, 1'b1, 1'b0);
    expect_write(11'd0, 32'h00000013);
    expect_write(11'd1, 32'h00100093);
    send_good_body(8'hB6);
    check_status("t4_recover", 1'b1, 1'b0, 1'b0);

    // 5: empty image, then junk in IDLE
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    check_status("t5", 1'b1, 1'b0, 1'b0);
    send(8'h3C); send(8'h7F);
    @(negedge clk);
    check_status("t5_junk", 1'b1, 1'b0, 1'b0);

    // 6: reset mid-frame after two data bytes
    send(8'hA5); send(8'h01); send(8'h00); send(8'h13); send(8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rx_ready", 32'(rx_ready), 32'd0);
    check("t6_mem_we", 32'(mem_we), 32'd0);
    check_status("t6_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    send(8'h00); send(8'h93); send(8'h00); send(8'h10); send(8'h00); send(8'h00);
    repeat (3) @(negedge clk);
    check_status("t6_after", 1'b0, 1'b0, 1'b0);

    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
